// File: rtl/rgb_sequencer_if.sv
// Colour sequencer link: button and breath tick in,
// colour and mode out toward the breathing-light PWM stage.
interface rgb_sequencer_if;
    logic       breath_i;
    logic       btn_i;
    logic [2:0] rgb_o;
    logic [1:0] mode_o;

    modport master (
        output breath_i,
        output btn_i,
        input  rgb_o,
        input  mode_o
    );

    modport slave (
        input  breath_i,
        input  btn_i,
        output rgb_o,
        output mode_o
    );
endinterface

// File: rtl/rgb_sequencer.sv
// Debounced mode button plus breath-tick colour stepping,
// feeding a registered {r,g,b} to the breather.
module rgb_sequencer #(
    parameter int DEBOUNCE_CYCLES = 156250
) (
    input logic           clk_div_i,
    input logic           rst_n_i,
    rgb_sequencer_if.slave bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        WHITE   = 2'd0,
        RAINBOW = 2'd1,
        PRIMARY = 2'd2,
        OFF     = 2'd3
    } mode_e;

    logic          s1, s2, deb, deb_q, breath_q;
    logic [CW-1:0] cnt;
    logic          press, step;

    mode_e         mode_q, mode_d;
    logic [2:0]    idx_q, idx_d;
    logic [2:0]    rgb_q, rgb_d;

    function automatic logic [2:0] colour(mode_e m, logic [2:0] i);
        logic [2:0] c;
        c = 3'b111;
        case (m)
            WHITE: c = 3'b111;
            RAINBOW: begin
                case (i)
                    3'd1:    c = 3'b010;
                    3'd2:    c = 3'b100;
                    3'd3:    c = 3'b011;
                    3'd4:    c = 3'b110;
                    3'd5:    c = 3'b101;
                    3'd6:    c = 3'b111;
                    default: c = 3'b001;
                endcase
            end
            PRIMARY: begin
                case (i)
                    3'd1:    c = 3'b010;
                    3'd2:    c = 3'b001;
                    default: c = 3'b100;
                endcase
            end
            OFF: c = 3'b000;
        endcase
        return c;
    endfunction

    // breath_q resets high so a high breath_i at release is not a step
    always_ff @(posedge clk_div_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            deb      <= 1'b0;
            deb_q    <= 1'b0;
            cnt      <= '0;
            breath_q <= 1'b1;
        end else begin
            s1       <= bus.btn_i;
            s2       <= s1;
            deb_q    <= deb;
            breath_q <= bus.breath_i;
            unique case (1'b1)
                (s2 == deb): cnt <= '0;
                (s2 != deb && cnt == CNT_MAX): begin
                    deb <= s2;
                    cnt <= '0;
                end
                default: cnt <= cnt + 1'b1;
            endcase
        end
    end

    assign press = deb & ~deb_q;
    assign step  = bus.breath_i & ~breath_q;

    always_comb begin
        mode_d = mode_q;
        idx_d  = idx_q;
        if (press) begin
            idx_d = '0;
            unique case (mode_q)
                WHITE:   mode_d = RAINBOW;
                RAINBOW: mode_d = PRIMARY;
                PRIMARY: mode_d = OFF;
                OFF:     mode_d = WHITE;
            endcase
        end else if (step) begin
            unique case (mode_q)
                RAINBOW: idx_d = (idx_q >= 3'd6) ? 3'd0 : idx_q + 3'd1;
                PRIMARY: idx_d = (idx_q >= 3'd2) ? 3'd0 : idx_q + 3'd1;
                default: idx_d = idx_q;
            endcase
        end
        rgb_d = colour(mode_d, idx_d);
    end

    always_ff @(posedge clk_div_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mode_q <= WHITE;
            idx_q  <= '0;
            rgb_q  <= 3'b111;
        end else begin
            mode_q <= mode_d;
            idx_q  <= idx_d;
            rgb_q  <= rgb_d;
        end
    end

    assign bus.rgb_o  = rgb_q;
    assign bus.mode_o = mode_q;
endmodule
